// File: rtl/cpu_step_ctrl.sv
// Execution controller for the board-level MIPS pipeline: turns debounced button
// pulses into the CPU clock-enable (halt / single-step / run / slow run) with a PC breakpoint.
module cpu_step_ctrl #(
  parameter logic [23:0] SLOW_DIV = 24'd5_000_000,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_p,
  input  logic          run_p,
  input  logic          slow_p,
  input  logic          halt_p,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc,
  output logic          cpu_ce,
  output logic [1:0]    mode,
  output logic          bp_hit,
  output logic [15:0]   step_cnt
);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SLOW = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [23:0] div_cnt_q, div_cnt_d;
  logic        skip_q, skip_d;
  logic        bp_hit_q, bp_hit_d;
  logic [15:0] step_cnt_q, step_cnt_d;

  logic tick_s;
  logic ce_raw_s;
  logic active_s;
  logic bp_match_s;
  logic bp_stop_s;
  logic cpu_ce_s;
  logic enter_active_s;
  logic leave_halt_s;

  // Enable generation: what the current state wants, then gated by the breakpoint.
  always_comb begin
    tick_s   = 1'b0;
    ce_raw_s = 1'b0;
    active_s = 1'b0;
    case (state_q)
      ST_HALT: begin
        ce_raw_s = 1'b0;
      end
      ST_RUN: begin
        ce_raw_s = 1'b1;
        active_s = 1'b1;
      end
      ST_SLOW: begin
        tick_s   = (div_cnt_q == (SLOW_DIV - 24'd1));
        ce_raw_s = tick_s;
        active_s = 1'b1;
      end
      ST_STEP: begin
        ce_raw_s = 1'b1;
      end
      default: begin
        ce_raw_s = 1'b0;
      end
    endcase
    // skip lets a resumed run execute the instruction it stopped on
    bp_match_s = active_s & bp_en & (pc == bp_addr) & ~skip_q;
    bp_stop_s  = ce_raw_s & bp_match_s;
    cpu_ce_s   = ce_raw_s & ~bp_stop_s;
  end

  // Next-state selection; pulse priority is halt > run > slow > step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (halt_p) begin
          state_d = ST_HALT;
        end else if (run_p) begin
          state_d = ST_RUN;
        end else if (slow_p) begin
          state_d = ST_SLOW;
        end else if (step_p) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (halt_p) begin
          state_d = ST_HALT;
        end else if (run_p) begin
          state_d = ST_RUN;
        end else if (slow_p) begin
          state_d = ST_SLOW;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (bp_stop_s || halt_p || run_p) begin
          state_d = ST_HALT;
        end else if (slow_p) begin
          state_d = ST_SLOW;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SLOW: begin
        if (bp_stop_s || halt_p) begin
          state_d = ST_HALT;
        end else if (run_p) begin
          state_d = ST_RUN;
        end else if (slow_p) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_SLOW;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Divider, resume-skip, sticky breakpoint flag and enable counter.
  always_comb begin
    enter_active_s = (state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_SLOW));
    leave_halt_s   = (state_q == ST_HALT) && (state_d != ST_HALT);

    // the divider only runs while staying in SLOW, so every entry starts from 0
    if ((state_q == ST_SLOW) && (state_d == ST_SLOW)) begin
      div_cnt_d = tick_s ? 24'd0 : (div_cnt_q + 24'd1);
    end else begin
      div_cnt_d = 24'd0;
    end

    if (enter_active_s) begin
      skip_d = 1'b1;
    end else if (cpu_ce_s) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end

    if (bp_stop_s) begin
      bp_hit_d = 1'b1;
    end else if (leave_halt_s) begin
      bp_hit_d = 1'b0;
    end else begin
      bp_hit_d = bp_hit_q;
    end

    if (cpu_ce_s) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_HALT;
      div_cnt_q  <= 24'd0;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
      step_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign cpu_ce   = cpu_ce_s;
  assign mode     = state_q;
  assign bp_hit   = bp_hit_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution controller for the board-level MIPS pipeline. It turns one-cycle button pulses from the debounce units into a clock-enable for the CPU, supporting halt, single-step, full-speed run and slow run, with a PC breakpoint. It sits between the debounced buttons and the pipeline's global `cpu_ce`, and exposes mode, breakpoint status and an executed-cycle counter for the display logic.

## Interface
- `SLOW_DIV`, default 24'd5_000_000: clk cycles per enable tick in SLOW mode; legal range ≥ 2.
- `AW`, default 32: PC / breakpoint address width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `step_p` in 1: one-cycle pulse requesting a single step.
- `run_p` in 1: one-cycle pulse that toggles full-speed run.
- `slow_p` in 1: one-cycle pulse that enters slow run.
- `halt_p` in 1: one-cycle pulse that forces halt.
- `bp_en` in 1: breakpoint enable, level.
- `bp_addr` in AW: breakpoint PC.
- `pc` in AW: current fetch PC of the CPU; it advances only on cycles with `cpu_ce`=1.
- `cpu_ce` out 1: CPU clock-enable, combinational from registered state.
- `mode` out 2: 0=HALT, 1=RUN, 2=SLOW, 3=STEP.
- `bp_hit` out 1: sticky flag, set when a breakpoint stops execution.
- `step_cnt` out 16: count of cycles with `cpu_ce`=1.

## Operation
- **States:** HALT, STEP, RUN, SLOW. `mode` is the state encoding.
- **Pulse priority** when several pulses arrive in the same cycle: `halt_p` > `run_p` > `slow_p` > `step_p`. Lower-priority pulses in that cycle are discarded.
- **HALT:**
  - `step_p` → STEP.
  - `run_p` → RUN.
  - `slow_p` → SLOW.
  - `halt_p` → stay in HALT.
- **STEP:**
  - Lasts exactly one cycle; `cpu_ce`=1 for that cycle.
  - Next state is HALT.
  - Exceptions: `run_p` → RUN, `slow_p` → SLOW.
  - `step_p` in this cycle is ignored.
- **RUN:**
  - `cpu_ce`=1 every cycle unless the breakpoint blocks it.
  - `run_p` or `halt_p` → HALT.
  - `slow_p` → SLOW.
  - `step_p` is ignored.
- **SLOW:**
  - Divider `div_cnt` counts 0..SLOW_DIV-1 and wraps.
  - `tick` = (`div_cnt`==SLOW_DIV-1).
  - `cpu_ce` = `tick`, unless the breakpoint blocks it.
  - `div_cnt` clears to 0 on every entry into SLOW.
  - `halt_p` or `slow_p` → HALT.
  - `run_p` → RUN.
  - `step_p` is ignored.
- **Breakpoint:**
  - `bp_match` = `bp_en` & (`pc`==`bp_addr`) & `skip`==0, evaluated only in RUN/SLOW.
  - On a cycle where `cpu_ce` would otherwise be 1 and `bp_match`=1:
    - `cpu_ce` is forced to 0.
    - Next state is HALT.
    - `bp_hit` is set to 1.
  - The instruction at `bp_addr` is therefore not advanced past.
  - A breakpoint takes precedence over a `run_p`/`slow_p` arriving in the same cycle.
  - STEP ignores the breakpoint.
- **Resume past a breakpoint:**
  - The `skip` register is set on every transition into RUN or SLOW.
  - It is cleared on the first cycle in which `cpu_ce`=1.
  - This lets execution resume from a stopped-at breakpoint.
- **`bp_hit`:** cleared when `step_p`, `run_p` or `slow_p` is accepted (causes a state change out of HALT).
- **`step_cnt`:** increments on every cycle with `cpu_ce`=1 and wraps 0xFFFF → 0x0000. It is cleared only by reset.
- **Reset mid-operation:** reset returns the block to HALT from any state in one edge and aborts any pending slow tick.

## Timing
- Reset values:
  - state = HALT, so `mode`=0.
  - `cpu_ce`=0.
  - `bp_hit`=0.
  - `step_cnt`=0.
  - `div_cnt`=0.
  - `skip`=0.
- Pulse-to-enable latency is 1 cycle: a pulse sampled at edge t changes state, and `cpu_ce` reflects the new state during cycle t+1.
- Single step: `step_p` high in cycle t → `cpu_ce` high only in cycle t+1, `mode`=0 again in t+2.
- SLOW: first `cpu_ce` pulse comes SLOW_DIV cycles after entry. Each pulse is exactly 1 cycle wide, with period SLOW_DIV.
- Breakpoint stop: `cpu_ce` is gated low in the same cycle `pc` matches. `mode`=0 and `bp_hit`=1 from the next cycle.
- `cpu_ce` is glitch-free with respect to `clk`. `pc`/`bp_addr` must be stable before the setup window (synchronous to `clk`).

## Test plan
- **Reset and step:** release reset, pulse `step_p` at cycle 10 → `cpu_ce`=1 only in cycle 11, `step_cnt`=1, `mode`=0 at cycle 12. Repeat ×3 → `step_cnt`=4.
- **Run toggle and priority:**
  - `run_p` → `cpu_ce` continuous; after 100 cycles, `run_p` again → halt with `step_cnt`=100.
  - Same-cycle `halt_p`+`run_p` from HALT → stay HALT.
  - Same-cycle `run_p`+`step_p` → RUN.
- **Slow mode with SLOW_DIV=4:** `slow_p` → `cpu_ce` pulses at cycles 4, 8, 12 after entry. `run_p` mid-count → RUN next cycle. Re-entering SLOW restarts the count from 0.
- **Breakpoint:**
  - `bp_en`=1, `bp_addr`=0x20, CPU model with `pc`+=4 per `cpu_ce`, from `pc`=0; `run_p` → exactly 8 enables, `cpu_ce`=0 while `pc`=0x20, `bp_hit`=1, `mode`=0.
  - `run_p` again → `bp_hit`=0, `pc` advances to 0x24 and beyond.
- **Step over breakpoint:** with `pc`==`bp_addr`, `step_p` → one enable, `bp_hit` stays 0.
- **Counter wrap and reset mid-run:**
  - Force `step_cnt` to 0xFFFE in RUN → wraps to 0x0000 after 2 enables.
  - Assert `rst_n`=0 during RUN → next cycle `cpu_ce`=0, `mode`=0, `step_cnt`=0.
